// File: rtl/fsmc_console_writer.sv
// fsmc_console_writer
// Turns FSMC bus register writes into character-cell writes for char_buf.
// Keeps a hardware text cursor (CR/LF, auto-advance, wrap without scrolling),
// runs a one-cell-per-cycle clear-screen sweep, and provides register
// read-back for the bus slave. The char_buf write port is fully registered.

module fsmc_console_writer #(
   parameter int          ADRW  = 8,
   parameter int          DATW  = 16,
   parameter int          COLS  = 160,
   parameter int          ROWS  = 64,
   parameter int          COLW  = 8,
   parameter int          ROWW  = 7,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            do_write,
   input  logic [ADRW-1:0] w_adr,
   input  logic [DATW-1:0] w_data,
   input  logic [ADRW-1:0] r_adr,
   output logic [DATW-1:0] rd_data,
   output logic            buf_we,
   output logic [ROWW-1:0] buf_row,
   output logic [COLW-1:0] buf_col,
   output logic [7:0]      buf_data,
   output logic            busy
);

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   localparam logic [ADRW-1:0] A_CHAR = ADRW'(0);
   localparam logic [ADRW-1:0] A_COL  = ADRW'(1);
   localparam logic [ADRW-1:0] A_ROW  = ADRW'(2);
   localparam logic [ADRW-1:0] A_CTRL = ADRW'(3);

   localparam logic [COLW-1:0] COL_MAX  = COLW'(COLS - 1);
   localparam logic [ROWW-1:0] ROW_MAX  = ROWW'(ROWS - 1);
   localparam logic [7:0]      COL_LIM8 = 8'(COLS - 1);
   localparam logic [7:0]      ROW_LIM8 = 8'(ROWS - 1);
   localparam logic [7:0]      CH_CR    = 8'h0D;
   localparam logic [7:0]      CH_LF    = 8'h0A;
   localparam logic [7:0]      DROP_MAX = 8'hFF;

   state_t          state, state_n;
   logic [COLW-1:0] cur_col, col_n;
   logic [ROWW-1:0] cur_row, row_n;
   logic [7:0]      drop_cnt, drop_n;
   logic            we_n, busy_n;
   logic [ROWW-1:0] brow_n;
   logic [COLW-1:0] bcol_n;
   logic [7:0]      bdata_n;

   // Only the low byte of a bus write carries information.
   logic [7:0]      wch;
   logic            unused_wdata;
   assign wch          = w_data[7:0];
   assign unused_wdata = ^w_data[DATW-1:8];

   // Cursor row after a line advance; the bottom row wraps to the top.
   logic [ROWW-1:0] row_inc;
   assign row_inc = (cur_row == ROW_MAX) ? '0 : cur_row + ROWW'(1);

   // The sweep position is the cell currently on the buf_* outputs.
   logic            sweep_last;
   assign sweep_last = (buf_row == ROW_MAX) && (buf_col == COL_MAX);

   // State, cursor, drop counter and registered char_buf port.
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values computed by the combinational block below.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= S_IDLE;
         cur_col  <= '0;
         cur_row  <= '0;
         drop_cnt <= '0;
         buf_we   <= 1'b0;
         buf_row  <= '0;
         buf_col  <= '0;
         buf_data <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cur_col  <= col_n;
         cur_row  <= row_n;
         drop_cnt <= drop_n;
         buf_we   <= we_n;
         buf_row  <= brow_n;
         buf_col  <= bcol_n;
         buf_data <= bdata_n;
         busy     <= busy_n;
      end
   end

   // Next-state logic: register decode in IDLE, cell sweep and drop counting in CLEAR.
   always_comb begin
      // NOTE: every signal gets a hold/default value first so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_n = state;
      col_n   = cur_col;
      row_n   = cur_row;
      drop_n  = drop_cnt;
      we_n    = 1'b0;
      brow_n  = buf_row;
      bcol_n  = buf_col;
      bdata_n = buf_data;
      busy_n  = busy;

      case (state)
         S_IDLE: begin
            if (do_write) begin
               case (w_adr)
                  A_CHAR: begin
                     if (wch == CH_CR) begin
                        col_n = '0;
                     end else if (wch == CH_LF) begin
                        col_n = '0;
                        row_n = row_inc;
                     end else begin
                        we_n    = 1'b1;
                        brow_n  = cur_row;
                        bcol_n  = cur_col;
                        bdata_n = wch;
                        if (cur_col == COL_MAX) begin
                           col_n = '0;
                           row_n = row_inc;
                        end else begin
                           col_n = cur_col + COLW'(1);
                        end
                     end
                  end
                  A_COL:  col_n = (wch > COL_LIM8) ? COL_MAX : COLW'(wch);
                  A_ROW:  row_n = (wch > ROW_LIM8) ? ROW_MAX : ROWW'(wch);
                  A_CTRL: begin
                     if (w_data[0]) begin
                        // First cell goes out on the same edge busy rises.
                        state_n = S_CLEAR;
                        busy_n  = 1'b1;
                        we_n    = 1'b1;
                        brow_n  = '0;
                        bcol_n  = '0;
                        bdata_n = BLANK;
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_CLEAR: begin
            if (do_write && (drop_cnt != DROP_MAX)) begin
               drop_n = drop_cnt + 8'd1;
            end
            if (sweep_last) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               col_n   = '0;
               row_n   = '0;
            end else begin
               we_n = 1'b1;
               if (buf_col == COL_MAX) begin
                  bcol_n = '0;
                  brow_n = buf_row + ROWW'(1);
               end else begin
                  bcol_n = buf_col + COLW'(1);
               end
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   // Register read-back, zero-extended to the bus width.
   always_comb begin
      rd_data = '0;
      case (r_adr)
         A_CHAR:  rd_data = DATW'(busy);
         A_COL:   rd_data = DATW'(cur_col);
         A_ROW:   rd_data = DATW'(cur_row);
         A_CTRL:  rd_data = DATW'(drop_cnt);
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_fsmc_console_writer.sv
// Directed bench for fsmc_console_writer: cursor handling, wrap, clamp,
// clear sweep ordering, write dropping during clear, and reset abort.

module tb_fsmc_console_writer;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        do_write = 1'b0;
   logic [7:0]  w_adr = '0;
   logic [15:0] w_data = '0;
   logic [7:0]  r_adr = '0;
   logic [15:0] rd_data;
   logic        buf_we;
   logic [6:0]  buf_row;
   logic [7:0]  buf_col;
   logic [7:0]  buf_data;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   fsmc_console_writer dut (
      .clk      (clk),
      .nrst     (nrst),
      .do_write (do_write),
      .w_adr    (w_adr),
      .w_data   (w_data),
      .r_adr    (r_adr),
      .rd_data  (rd_data),
      .buf_we   (buf_we),
      .buf_row  (buf_row),
      .buf_col  (buf_col),
      .buf_data (buf_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge; drives a one-cycle strobe and returns at the next negedge,
   // where the registered response of that write is visible.
   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      w_adr    = a;
      w_data   = d;
      do_write = 1'b1;
      @(negedge clk);
      do_write = 1'b0;
   endtask

   task automatic rdc(input string tag, input logic [7:0] a, input logic [31:0] e);
      r_adr = a;
      #1;
      chk(tag, rd_data, e);
   endtask

   task automatic outc(input string tag, input logic we, input logic [6:0] row,
                       input logic [7:0] col, input logic [7:0] data);
      chk({tag, "_we"}, buf_we, we);
      chk({tag, "_row"}, buf_row, row);
      chk({tag, "_col"}, buf_col, col);
      chk({tag, "_data"}, buf_data, data);
   endtask

   initial begin
      int bad;
      int n;

      // T1: reset state and first character
      repeat (3) @(negedge clk);
      outc("reset", 1'b0, 7'd0, 8'd0, 8'h00);
      chk("reset_busy", busy, 1'b0);
      rdc("reset_col", 8'h01, 0);
      rdc("reset_row", 8'h02, 0);
      rdc("reset_drop", 8'h03, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      wr(8'h00, 16'h0041);
      outc("t1_char", 1'b1, 7'd0, 8'd0, 8'h41);
      rdc("t1_col", 8'h01, 1);
      @(negedge clk);
      chk("t1_we_pulse", buf_we, 1'b0);

      // T2: end-of-line wrap and bottom-right wrap
      wr(8'h01, 16'd159);
      wr(8'h02, 16'd5);
      wr(8'h00, 16'h0042);
      outc("t2_char", 1'b1, 7'd5, 8'd159, 8'h42);
      rdc("t2_col", 8'h01, 0);
      rdc("t2_row", 8'h02, 6);
      wr(8'h02, 16'd63);
      wr(8'h01, 16'd159);
      wr(8'h00, 16'h0043);
      outc("t2_corner", 1'b1, 7'd63, 8'd159, 8'h43);
      rdc("t2_wrap_col", 8'h01, 0);
      rdc("t2_wrap_row", 8'h02, 0);

      // Clamp and upper-bit masking
      wr(8'h01, 16'd200);
      rdc("clamp_col", 8'h01, 159);
      wr(8'h01, 16'hFF05);
      rdc("mask_col", 8'h01, 5);
      wr(8'h02, 16'd100);
      rdc("clamp_row", 8'h02, 63);

      // T3: CR and LF
      wr(8'h01, 16'd10);
      wr(8'h00, 16'h000D);
      chk("t3_cr_we", buf_we, 1'b0);
      rdc("t3_cr_col", 8'h01, 0);
      rdc("t3_cr_row", 8'h02, 63);
      wr(8'h01, 16'd7);
      wr(8'h00, 16'h000A);
      chk("t3_lf_we", buf_we, 1'b0);
      rdc("t3_lf_col", 8'h01, 0);
      rdc("t3_lf_row", 8'h02, 0);

      // Ignored address, CTRL no-op, unmapped read
      wr(8'h07, 16'h0041);
      chk("ign_we", buf_we, 1'b0);
      wr(8'h03, 16'h0002);
      chk("ctrl_nop_busy", busy, 1'b0);
      chk("ctrl_nop_we", buf_we, 1'b0);
      rdc("unmapped_rd", 8'h07, 0);

      // T4: full clear sweep, row-major, 10240 cycles
      wr(8'h02, 16'd3);
      wr(8'h01, 16'd4);
      wr(8'h03, 16'h0001);
      bad = 0;
      for (int k = 0; k < 10240; k++) begin
         if (!(buf_we === 1'b1 && busy === 1'b1 && buf_row === 7'(k / 160) &&
               buf_col === 8'(k % 160) && buf_data === 8'h20)) bad++;
         @(negedge clk);
      end
      chk("t4_sweep_cells", bad, 0);
      chk("t4_done_busy", busy, 1'b0);
      chk("t4_done_we", buf_we, 1'b0);
      rdc("t4_done_col", 8'h01, 0);
      rdc("t4_done_row", 8'h02, 0);
      rdc("t4_done_rdbusy", 8'h00, 0);

      // T5: back-to-back writes dropped during clear
      wr(8'h03, 16'h0001);
      rdc("t5_rdbusy", 8'h00, 1);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (buf_we === 1'b1 && buf_data === 8'h20) n++;
         if (i == 3) wr(8'h03, 16'h0001);
         else        wr(8'h00, 16'(16'h41 + i));
      end
      for (int i = 0; i < 12000; i++) begin
         if (busy !== 1'b1) break;
         if (buf_we === 1'b1 && buf_data === 8'h20) n++;
         @(negedge clk);
      end
      chk("t5_blank_cells", n, 10240);
      chk("t5_done_busy", busy, 1'b0);
      rdc("t5_drop", 8'h03, 4);
      rdc("t5_col", 8'h01, 0);

      // Write on the final sweep cycle is dropped too
      wr(8'h03, 16'h0001);
      for (int i = 0; i < 11000; i++) begin
         if (buf_row === 7'd63 && buf_col === 8'd159) break;
         @(negedge clk);
      end
      chk("last_cell_row", buf_row, 7'd63);
      chk("last_cell_col", buf_col, 8'd159);
      wr(8'h00, 16'h0055);
      chk("last_busy", busy, 1'b0);
      chk("last_we", buf_we, 1'b0);
      rdc("last_col", 8'h01, 0);
      rdc("last_row", 8'h02, 0);
      rdc("last_drop", 8'h03, 5);
      wr(8'h00, 16'h0061);
      outc("post_clear", 1'b1, 7'd0, 8'd0, 8'h61);

      // drop_cnt saturation
      wr(8'h03, 16'h0001);
      for (int i = 0; i < 300; i++) wr(8'h00, 16'h0030);
      rdc("sat_drop", 8'h03, 255);
      for (int i = 0; i < 11000; i++) begin
         if (busy !== 1'b1) break;
         @(negedge clk);
      end
      chk("sat_done_busy", busy, 1'b0);
      rdc("sat_drop_after", 8'h03, 255);

      // T6: reset in the middle of a clear
      wr(8'h03, 16'h0001);
      repeat (499) @(negedge clk);
      chk("t6_mid_we", buf_we, 1'b1);
      chk("t6_mid_busy", busy, 1'b1);
      nrst = 1'b0;
      @(negedge clk);
      outc("t6_rst", 1'b0, 7'd0, 8'd0, 8'h00);
      chk("t6_rst_busy", busy, 1'b0);
      rdc("t6_rst_col", 8'h01, 0);
      rdc("t6_rst_row", 8'h02, 0);
      rdc("t6_rst_drop", 8'h03, 0);
      @(negedge clk);
      nrst = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (buf_we !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("t6_no_resume", bad, 0);
      wr(8'h00, 16'h007A);
      outc("t6_char", 1'b1, 7'd0, 8'd0, 8'h7A);
      rdc("t6_col", 8'h01, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
